// File: rtl/otter_fetch_pkg.sv
// Shared definitions for the OTTER instruction fetch unit: FSM encoding,
// PC step and default reset vector.
package otter_fetch_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int unsigned PC_INCR = 4;

    localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;

endpackage

// File: rtl/otter_fetch_fifo.sv
// Small instruction queue holding {pc, instr} entries; head is read
// combinationally, flush empties it in one cycle and beats push/pop.
module otter_fetch_fifo #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  store_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;
    logic          wr_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = store_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_en    = do_push && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) store_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/otter_ifetch.sv
// OTTER instruction fetch: single-outstanding req/gnt/rvalid reader that
// fills a small {pc, instr} queue drained by decode; redirect flushes.
module otter_ifetch
    import otter_fetch_pkg::*;
#(
    parameter int unsigned    AW         = 32,
    parameter int unsigned    DW         = 32,
    parameter int unsigned    DEPTH      = 2,
    parameter logic [AW-1:0]  RESET_ADDR = AW'(RESET_ADDR_DEF)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          ir_valid,
    output logic [DW-1:0] ir_data,
    output logic [AW-1:0] ir_pc,
    input  logic          ir_ready
);

    localparam int unsigned   CW         = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] ALIGN_MASK = {{(AW-2){1'b1}}, 2'b00};

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    fetch_addr_q, fetch_addr_d;
    logic [AW-1:0]    req_pc_q, req_pc_d;
    logic             mem_req_q, mem_req_d;
    logic [AW-1:0]    redirect_tgt;
    logic             slot_free;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic [AW+DW-1:0] fifo_wdata;
    logic [AW+DW-1:0] fifo_head;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic             fifo_full;

    assign redirect_tgt = redirect_pc & ALIGN_MASK;
    assign fifo_flush   = redirect;
    assign fifo_pop     = !fifo_empty && ir_ready;
    assign fifo_wdata   = {req_pc_q, mem_rdata};

    otter_fetch_fifo #(
        .W     (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (fifo_wdata),
        .rdata (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        req_pc_d     = req_pc_q;
        fifo_push    = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A redirect coinciding with a grant still owes us a response.
                if (mem_req_q && mem_gnt) begin
                    req_pc_d     = fetch_addr_q;
                    fetch_addr_d = fetch_addr_q + AW'(PC_INCR);
                    state_d      = redirect ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    fifo_push = !redirect;
                    state_d   = ST_RUN;
                end else if (redirect) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        if (redirect) fetch_addr_d = redirect_tgt;
    end

    // Occupancy after this edge decides whether the next request may issue.
    always_comb begin
        if (fifo_flush) begin
            slot_free = 1'b1;
        end else if (fifo_push) begin
            slot_free = fifo_pop || (fifo_count < CW'(DEPTH - 1));
        end else begin
            slot_free = fifo_pop || !fifo_full;
        end
        mem_req_d = (state_d == ST_RUN) && slot_free;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= ST_RUN;
            fetch_addr_q <= RESET_ADDR;
            mem_req_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            mem_req_q    <= mem_req_d;
        end
    end

    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = fetch_addr_q;
    assign ir_valid = !fifo_empty;
    assign ir_data  = fifo_empty ? '0 : fifo_head[DW-1:0];
    assign ir_pc    = fifo_empty ? '0 : fifo_head[AW+DW-1:DW];

endmodule

// File: tb/tb_otter_ifetch.sv
// Self-checking bench for otter_ifetch: random memory/decode behaviour
// scored against a transaction-level queue model of the fetch unit.
module tb_otter_ifetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RST_A = 32'h0000_0000;
    localparam logic [31:0] RST_W = 32'hFFFF_FFF8;

    logic        clk;
    logic        clr, redirect, mem_req, mem_gnt, mem_rvalid, ir_valid, ir_ready;
    logic [31:0] redirect_pc, mem_addr, mem_rdata, ir_data, ir_pc;
    logic        w_clr, w_redirect, w_mem_req, w_mem_gnt, w_mem_rvalid, w_ir_valid, w_ir_ready;
    logic [31:0] w_redirect_pc, w_mem_addr, w_mem_rdata, w_ir_data, w_ir_pc;

    otter_ifetch #(.AW(32), .DW(32), .DEPTH(DEPTH), .RESET_ADDR(RST_A)) dut (
        .clk(clk), .clr(clr), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc), .ir_ready(ir_ready)
    );

    otter_ifetch #(.AW(32), .DW(32), .DEPTH(DEPTH), .RESET_ADDR(RST_W)) dut_w (
        .clk(clk), .clr(w_clr), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_gnt(w_mem_gnt),
        .mem_rvalid(w_mem_rvalid), .mem_rdata(w_mem_rdata),
        .ir_valid(w_ir_valid), .ir_data(w_ir_data), .ir_pc(w_ir_pc), .ir_ready(w_ir_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // stimulus policy
    int unsigned gnt_pct, ready_pct, redir_pct;
    int          min_lat, max_lat;
    logic        clr_now, redir_now;
    logic [31:0] redir_tgt;

    // reference model: expected queue contents and fetch pointer
    logic [31:0] q_pc[$];
    logic [31:0] q_data[$];
    logic [31:0] exp_fetch, pend_pc, dummy;
    bit          busy, live, exp_req;

    // memory responder
    bit          mem_pend;
    logic [31:0] mem_pend_addr;
    int          mem_lat;

    // per-step observations
    logic        s_req, s_ivalid;
    logic [31:0] s_addr, s_ipc, s_idata;
    bit          pop_now, push_now, g_now;
    logic [31:0] pop_pc, g_addr;

    task automatic step();
        bit          rv, g, rdy, rd, push_ok;
        logic [31:0] tgt;
        @(negedge clk);
        cyc++;
        s_req = mem_req; s_addr = mem_addr; s_ivalid = ir_valid; s_ipc = ir_pc; s_idata = ir_data;
        n_checks++;
        if (s_req !== exp_req) begin
            n_fail++; $display("FAIL mem_req cyc=%0d got=%b exp=%b", cyc, s_req, exp_req);
        end
        if (exp_req && s_req) begin
            n_checks++;
            if (s_addr !== exp_fetch) begin
                n_fail++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, s_addr, exp_fetch);
            end
        end
        n_checks++;
        if (s_ivalid !== (q_pc.size() != 0)) begin
            n_fail++; $display("FAIL ir_valid cyc=%0d got=%b exp=%b", cyc, s_ivalid, q_pc.size() != 0);
        end
        if (q_pc.size() != 0 && s_ivalid) begin
            n_checks++;
            if (s_ipc !== q_pc[0] || s_idata !== q_data[0]) begin
                n_fail++;
                $display("FAIL ir_head cyc=%0d got=%h/%h exp=%h/%h", cyc, s_ipc, s_idata, q_pc[0], q_data[0]);
            end
        end
        rv  = mem_pend && mem_lat == 0;
        g   = s_req && !mem_pend && !clr_now && ($urandom_range(99) < gnt_pct);
        rdy = $urandom_range(99) < ready_pct;
        rd  = redir_now && !clr_now;
        tgt = redir_tgt;
        if (!rd && !clr_now && redir_pct != 0 && $urandom_range(99) < redir_pct) begin
            rd  = 1'b1;
            tgt = $urandom;
        end
        clr = clr_now; mem_gnt = g; mem_rvalid = rv; ir_ready = rdy;
        mem_rdata = rv ? 32'h13 + mem_pend_addr : $urandom;
        redirect = rd; redirect_pc = tgt;
        redir_now = 1'b0;
        @(posedge clk);
        if (rv) mem_pend = 1'b0;
        else if (mem_pend) mem_lat--;
        if (g) begin
            mem_pend = 1'b1; mem_pend_addr = s_addr;
            mem_lat = min_lat + int'($urandom_range(max_lat - min_lat));
        end
        g_now = g; g_addr = s_addr;
        pop_now = 1'b0; push_now = 1'b0;
        if (clr_now) begin
            q_pc.delete(); q_data.delete();
            busy = 1'b0; live = 1'b0; exp_fetch = RST_A; exp_req = 1'b0;
        end else begin
            push_ok = rv && busy && live && !rd;
            if (rv && busy) busy = 1'b0;
            if (g) begin
                busy = 1'b1; live = !rd; pend_pc = exp_fetch; exp_fetch = exp_fetch + 32'd4;
            end
            if (rd) begin
                q_pc.delete(); q_data.delete();
                live = 1'b0; exp_fetch = tgt & ~32'h3;
            end else begin
                if (rdy && q_pc.size() != 0) begin
                    pop_now = 1'b1; pop_pc = s_ipc;
                    dummy = q_pc.pop_front(); dummy = q_data.pop_front();
                end
                if (push_ok) begin
                    push_now = 1'b1;
                    n_checks++;
                    if (q_pc.size() >= DEPTH) begin
                        n_fail++; $display("FAIL overflow cyc=%0d got=%0d exp<%0d", cyc, q_pc.size(), DEPTH);
                    end else begin
                        q_pc.push_back(pend_pc); q_data.push_back(32'h13 + pend_pc);
                    end
                end
            end
            exp_req = !busy && q_pc.size() < DEPTH;
        end
    endtask

    task automatic do_reset();
        clr_now = 1'b1;
        repeat (3) step();
        clr_now = 1'b0;
        step();
    endtask

    task automatic test_reset();
        gnt_pct = 0; ready_pct = 100; redir_pct = 0; min_lat = 0; max_lat = 0;
        clr_now = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (s_req !== 1'b0 || s_addr !== RST_A || s_ivalid !== 1'b0 || s_ipc !== 32'h0 || s_idata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_vals got req=%b addr=%h v=%b pc=%h d=%h exp 0/%h/0/0/0", s_req, s_addr, s_ivalid, s_ipc, s_idata, RST_A);
            end
        end
        clr_now = 1'b0;
        step();
        step();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0) begin
            n_fail++; $display("FAIL first_req got=%b/%h exp=1/00000000", s_req, s_addr);
        end
    endtask

    task automatic test_streaming();
        int          npop = 0;
        int          last = -1;
        logic [31:0] seen[$];
        do_reset();
        gnt_pct = 100; ready_pct = 100; min_lat = 0; max_lat = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (pop_now) begin
                if (last >= 0) begin
                    n_checks++;
                    if (cyc - last != 2) begin
                        n_fail++; $display("FAIL stream_gap got=%0d exp=2", cyc - last);
                    end
                end
                last = cyc; npop++; seen.push_back(pop_pc);
            end
        end
        n_checks++;
        if (npop != 19 || seen.size() < 3) begin
            n_fail++; $display("FAIL stream_count got=%0d exp=19", npop);
        end else begin
            n_checks++;
            if (seen[0] !== 32'h0 || seen[1] !== 32'h4 || seen[2] !== 32'h8) begin
                n_fail++; $display("FAIL stream_pcs got=%h,%h,%h exp=0,4,8", seen[0], seen[1], seen[2]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] seen[$];
        do_reset();
        gnt_pct = 100; ready_pct = 0; min_lat = 0; max_lat = 0;
        repeat (12) step();
        n_checks++;
        if (s_req !== 1'b0 || s_ivalid !== 1'b1 || s_ipc !== 32'h0 || s_idata !== 32'h13) begin
            n_fail++; $display("FAIL bp_full got req=%b v=%b pc=%h d=%h exp 0/1/0/13", s_req, s_ivalid, s_ipc, s_idata);
        end
        ready_pct = 100;
        for (int i = 0; i < 8; i++) begin
            step();
            if (pop_now) seen.push_back(pop_pc);
        end
        n_checks++;
        if (seen.size() < 3) begin
            n_fail++; $display("FAIL bp_drain got=%0d pops exp>=3", seen.size());
        end else if (seen[0] !== 32'h0 || seen[1] !== 32'h4 || seen[2] !== 32'h8) begin
            n_fail++; $display("FAIL bp_order got=%h,%h,%h exp=0,4,8", seen[0], seen[1], seen[2]);
        end
    endtask

    task automatic test_redirect_wait();
        bit hit = 1'b0;
        do_reset();
        gnt_pct = 100; ready_pct = 100; min_lat = 3; max_lat = 3;
        for (int i = 0; i < 20 && !(busy && mem_pend && mem_lat > 0); i++) step();
        redir_now = 1'b1; redir_tgt = 32'h1003;
        step();
        step();
        n_checks++;
        if (s_ivalid !== 1'b0) begin
            n_fail++; $display("FAIL rw_flush got=%b exp=0", s_ivalid);
        end
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            if (g_now) begin
                hit = 1'b1;
                n_checks++;
                if (g_addr !== 32'h1000) begin
                    n_fail++; $display("FAIL rw_addr got=%h exp=00001000", g_addr);
                end
            end
        end
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            if (pop_now) begin
                hit = 1'b1;
                n_checks++;
                if (pop_pc !== 32'h1000) begin
                    n_fail++; $display("FAIL rw_pc got=%h exp=00001000", pop_pc);
                end
            end
        end
        if (!hit) begin
            n_checks++; n_fail++; $display("FAIL rw_timeout got=none exp=pop");
        end
    endtask

    task automatic test_simultaneous();
        bit          hit = 1'b0;
        int          n_both = 0;
        logic [31:0] nxt = RST_A;
        do_reset();
        gnt_pct = 100; ready_pct = 100; min_lat = 2; max_lat = 2;
        for (int i = 0; i < 20 && !(busy && mem_pend && mem_lat == 0); i++) step();
        redir_now = 1'b1; redir_tgt = 32'h2000;
        step();
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            if (pop_now) begin
                hit = 1'b1;
                n_checks++;
                if (pop_pc !== 32'h2000) begin
                    n_fail++; $display("FAIL sim_rv_redir got=%h exp=00002000", pop_pc);
                end
            end
        end
        if (!hit) begin
            n_checks++; n_fail++; $display("FAIL sim_timeout got=none exp=pop");
        end
        do_reset();
        gnt_pct = 100; ready_pct = 50; min_lat = 0; max_lat = 1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (pop_now && push_now) n_both++;
            if (pop_now) begin
                n_checks++;
                if (pop_pc !== nxt) begin
                    n_fail++; $display("FAIL sim_order got=%h exp=%h", pop_pc, nxt);
                end
                nxt = nxt + 32'd4;
            end
        end
        n_checks++;
        if (n_both == 0) begin
            n_fail++; $display("FAIL sim_pushpop got=0 exp>0");
        end
    endtask

    task automatic test_random();
        do_reset();
        gnt_pct = 70; ready_pct = 60; redir_pct = 4; min_lat = 0; max_lat = 3;
        repeat (600) step();
        redir_pct = 0;
    endtask

    task automatic test_clr_mid_wait();
        bit hit = 1'b0;
        do_reset();
        gnt_pct = 100; ready_pct = 100; min_lat = 4; max_lat = 4;
        for (int i = 0; i < 20 && !(busy && mem_pend && mem_lat >= 2); i++) step();
        clr_now = 1'b1;
        step();
        step();
        clr_now = 1'b0;
        step();
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            if (g_now) begin
                hit = 1'b1;
                n_checks++;
                if (g_addr !== RST_A) begin
                    n_fail++; $display("FAIL clr_restart got=%h exp=%h", g_addr, RST_A);
                end
            end
        end
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            if (pop_now) begin
                hit = 1'b1;
                n_checks++;
                if (pop_pc !== RST_A) begin
                    n_fail++; $display("FAIL clr_first_pc got=%h exp=%h", pop_pc, RST_A);
                end
            end
        end
        if (!hit) begin
            n_checks++; n_fail++; $display("FAIL clr_timeout got=none exp=pop");
        end
    endtask

    task automatic test_wrap();
        bit          pend = 1'b0;
        bit          rv;
        logic [31:0] paddr = 32'h0;
        logic [31:0] gl[$];
        logic [31:0] pl[$];
        clr_now = 1'b1;
        step();
        @(negedge clk);
        n_checks++;
        if (w_mem_req !== 1'b0 || w_mem_addr !== RST_W || w_ir_valid !== 1'b0) begin
            n_fail++; $display("FAIL wrap_reset got=%b/%h/%b exp=0/%h/0", w_mem_req, w_mem_addr, w_ir_valid, RST_W);
        end
        w_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (w_ir_valid) begin
                pl.push_back(w_ir_pc);
                n_checks++;
                if (w_ir_data !== 32'h13 + w_ir_pc) begin
                    n_fail++; $display("FAIL wrap_data got=%h exp=%h", w_ir_data, 32'h13 + w_ir_pc);
                end
            end
            rv = pend;
            w_mem_rvalid = rv;
            w_mem_rdata = 32'h13 + paddr;
            w_mem_gnt = w_mem_req && !pend;
            pend = 1'b0;
            if (w_mem_gnt) begin
                gl.push_back(w_mem_addr); pend = 1'b1; paddr = w_mem_addr;
            end
        end
        n_checks++;
        if (gl.size() < 3 || pl.size() < 3) begin
            n_fail++; $display("FAIL wrap_count got=%0d/%0d exp>=3", gl.size(), pl.size());
        end else if (gl[0] !== 32'hFFFFFFF8 || gl[1] !== 32'hFFFFFFFC || gl[2] !== 32'h0 ||
                     pl[0] !== 32'hFFFFFFF8 || pl[1] !== 32'hFFFFFFFC || pl[2] !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_seq got=%h,%h,%h pc=%h,%h,%h exp=fffffff8,fffffffc,00000000", gl[0], gl[1], gl[2], pl[0], pl[1], pl[2]);
        end
    endtask

    initial begin
        clr = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = '0; ir_ready = 1'b0;
        w_clr = 1'b1; w_redirect = 1'b0; w_redirect_pc = '0; w_mem_gnt = 1'b0;
        w_mem_rvalid = 1'b0; w_mem_rdata = '0; w_ir_ready = 1'b1;
        clr_now = 1'b1; redir_now = 1'b0; redir_tgt = '0;
        gnt_pct = 0; ready_pct = 0; redir_pct = 0; min_lat = 0; max_lat = 0;
        busy = 1'b0; live = 1'b0; exp_req = 1'b0; exp_fetch = RST_A; pend_pc = '0;
        mem_pend = 1'b0; mem_pend_addr = '0; mem_lat = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_wait();
        test_simultaneous();
        test_random();
        test_clr_mid_wait();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
